// File: rtl/xpe_neuron_seq.sv
// Sequences one binary-neuron dot product through an XNOR-popcount core:
// streams N word pairs with a tail mask, accumulates popcounts, emits score and bit.
module xpe_neuron_seq #(
  parameter  int WORD_SIZE = 64,
  parameter  int MAX_WORDS = 16,
  parameter  int PIPELINE  = 1,
  localparam int CNT_W     = $clog2(MAX_WORDS + 1),
  localparam int PCW       = $clog2(WORD_SIZE + 1),
  localparam int ACC_W     = $clog2(MAX_WORDS * WORD_SIZE + 1),
  localparam int SW        = ACC_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_words,
  input  logic [PCW-1:0]       last_bits,
  input  logic [SW-1:0]        threshold,
  output logic                 busy,
  output logic                 rd_en,
  output logic [CNT_W-1:0]     rd_addr,
  input  logic [WORD_SIZE-1:0] rd_w,
  input  logic [WORD_SIZE-1:0] rd_a,
  output logic [WORD_SIZE-1:0] core_w,
  output logic [WORD_SIZE-1:0] core_a,
  output logic [WORD_SIZE-1:0] core_mask,
  output logic                 core_ce,
  input  logic [PCW-1:0]       core_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SW-1:0]        out_score,
  output logic                 out_bit
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  localparam logic [PCW-1:0]   WS_P  = PCW'(WORD_SIZE);
  localparam logic [CNT_W-1:0] MAX_P = CNT_W'(MAX_WORDS);

  logic [1:0]             state;
  logic [1:0]             state_nx;
  logic [CNT_W-1:0]       n_words;
  logic [PCW-1:0]         lb_eff;
  logic signed [SW-1:0]   thr;
  logic [ACC_W-1:0]       total;
  logic [ACC_W-1:0]       acc;
  logic [PIPELINE:0]      tag_v;
  logic                   tag_l;

  logic [CNT_W-1:0]       n_in;
  logic [PCW-1:0]         lb_in;
  logic [ACC_W-1:0]       total_in;
  logic signed [SW-1:0]   score_s;
  logic                   fetch_last;

  // Clamp the requested configuration; last_bits of 0 means a full final word.
  assign n_in     = (num_words > MAX_P) ? MAX_P : num_words;
  assign lb_in    = ((last_bits == {PCW{1'b0}}) || (last_bits > WS_P)) ? WS_P : last_bits;
  assign total_in = ACC_W'(n_in) * ACC_W'(WORD_SIZE) - ACC_W'(WORD_SIZE) + ACC_W'(lb_in);

  // Wraps modulo 2^SW on the doubling; the difference always fits.
  assign score_s    = $signed({acc, 1'b0}) - $signed({1'b0, total});
  assign fetch_last = (rd_addr == (n_words - CNT_W'(1)));

  assign core_w  = rd_w;
  assign core_a  = rd_a;
  assign core_ce = ~rst;

  // Tail mask applies only while the final word sits at the core inputs.
  always_comb begin
    core_mask = {WORD_SIZE{1'b1}};
    if (tag_v[0] && tag_l) begin
      core_mask = {WORD_SIZE{1'b1}} >> (WS_P - lb_eff);
    end else begin
      core_mask = {WORD_SIZE{1'b1}};
    end
  end

  // Next-state logic for the neuron sequencer.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (n_in == {CNT_W{1'b0}}) ? S_RESULT : S_FETCH;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_FETCH: begin
        if (fetch_last) state_nx = S_DRAIN;
        else            state_nx = S_FETCH;
      end
      S_DRAIN: begin
        if (tag_v == {(PIPELINE + 1){1'b0}}) state_nx = S_RESULT;
        else                                 state_nx = S_DRAIN;
      end
      S_RESULT: begin
        if (out_ready) state_nx = S_IDLE;
        else           state_nx = S_RESULT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, configuration, read sequencing, tag pipe, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= {CNT_W{1'b0}};
      n_words   <= {CNT_W{1'b0}};
      lb_eff    <= WS_P;
      thr       <= {SW{1'b0}};
      total     <= {ACC_W{1'b0}};
      acc       <= {ACC_W{1'b0}};
      tag_v     <= {(PIPELINE + 1){1'b0}};
      tag_l     <= 1'b0;
      out_valid <= 1'b0;
      out_score <= {SW{1'b0}};
      out_bit   <= 1'b0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != S_IDLE);
      tag_v[0] <= rd_en;
      tag_l    <= rd_en && fetch_last;
      for (int i = 1; i <= PIPELINE; i++) begin
        tag_v[i] <= tag_v[i-1];
      end
      if (tag_v[PIPELINE]) begin
        acc <= acc + ACC_W'(core_pc);
      end else begin
        acc <= acc;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            n_words <= n_in;
            lb_eff  <= lb_in;
            thr     <= $signed(threshold);
            total   <= total_in;
            acc     <= {ACC_W{1'b0}};
            rd_addr <= {CNT_W{1'b0}};
            rd_en   <= (n_in != {CNT_W{1'b0}});
            if (n_in == {CNT_W{1'b0}}) begin
              out_valid <= 1'b1;
              out_score <= {SW{1'b0}};
              out_bit   <= ($signed(threshold) <= $signed({SW{1'b0}}));
            end else begin
              out_valid <= 1'b0;
            end
          end else begin
            rd_en <= 1'b0;
          end
        end
        S_FETCH: begin
          if (fetch_last) rd_en <= 1'b0;
          else            rd_addr <= rd_addr + CNT_W'(1);
        end
        S_DRAIN: begin
          if (tag_v == {(PIPELINE + 1){1'b0}}) begin
            out_valid <= 1'b1;
            out_score <= score_s;
            out_bit   <= (score_s >= thr);
          end else begin
            out_valid <= 1'b0;
          end
        end
        S_RESULT: begin
          if (out_ready) out_valid <= 1'b0;
          else           out_valid <= 1'b1;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xpe_neuron_seq.sv
// Randomized bench for xpe_neuron_seq with a behavioural buffer/core and a
// word-level reference model of score, bit, latency and read sequence.
module tb_xpe_neuron_seq;

  logic        clk = 1'b0;
  logic        rst, start, busy, rd_en, core_ce, out_valid, out_ready, out_bit;
  logic [4:0]  num_words, rd_addr;
  logic [6:0]  last_bits, core_pc;
  logic [11:0] threshold, out_score;
  logic [63:0] rd_w, rd_a, core_w, core_a, core_mask;

  logic [63:0] w_mem [16];
  logic [63:0] a_mem [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xpe_neuron_seq dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .last_bits(last_bits), .threshold(threshold), .busy(busy),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_w(rd_w), .rd_a(rd_a),
    .core_w(core_w), .core_a(core_a), .core_mask(core_mask),
    .core_ce(core_ce), .core_pc(core_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_score(out_score), .out_bit(out_bit)
  );

  // Buffer: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_w <= w_mem[rd_addr[3:0]];
      rd_a <= a_mem[rd_addr[3:0]];
    end
  end

  // One-cycle XNOR-popcount core.
  always @(posedge clk) begin
    if (core_ce) core_pc <= 7'($countones(~(core_w ^ core_a) & core_mask));
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // pat: 0 random, 1 all ones, 2 w=0/a=ones, 3 w=a except word1 upper bits
  task automatic run_neuron(input int n, input int lb, input int thr_v, input bit thr_rel,
                            input int pat, input bit stall);
    int n_eff, lb_eff, exp_acc, exp_total, exp_score, thr, cyc, reads;
    bit last_pending, done, first;
    logic [63:0] em, m;
    logic [11:0] held_score;
    for (int i = 0; i < 16; i++) begin
      case (pat)
        1:       begin w_mem[i] = '1; a_mem[i] = '1; end
        2:       begin w_mem[i] = '0; a_mem[i] = '1; end
        3:       begin w_mem[i] = {$urandom, $urandom}; a_mem[i] = w_mem[i];
                       if (i == 1) a_mem[i] = w_mem[i] ^ {54'h3F_FFFF_FFFF_FFFF, 10'h0}; end
        default: begin w_mem[i] = {$urandom, $urandom}; a_mem[i] = {$urandom, $urandom}; end
      endcase
    end
    n_eff  = (n > 16) ? 16 : n;
    lb_eff = (lb == 0 || lb > 64) ? 64 : lb;
    em = '1;
    if (lb_eff < 64) em = (64'd1 << lb_eff) - 64'd1;
    exp_acc = 0;
    for (int i = 0; i < n_eff; i++) begin
      m = (i == n_eff - 1) ? em : '1;
      exp_acc += $countones(~(w_mem[i] ^ a_mem[i]) & m);
    end
    exp_total = (n_eff == 0) ? 0 : (n_eff - 1) * 64 + lb_eff;
    exp_score = 2 * exp_acc - exp_total;
    thr = thr_rel ? exp_score + thr_v : thr_v;

    start = 1'b1; num_words = 5'(n); last_bits = 7'(lb); threshold = 12'(thr);
    out_ready = !stall;
    cyc = 0; reads = 0; last_pending = 0; done = 0; first = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      if (first) begin start = 1'b0; first = 0; end
      cyc++;
      if (last_pending) begin
        check_val("tail_mask", longint'(core_mask), longint'(em));
        last_pending = 0;
      end
      if (rd_en) begin
        check_val("rd_addr", rd_addr, reads);
        if (reads == n_eff - 1) last_pending = 1;
        reads++;
      end
      if (out_valid) done = 1;
    end
    check_val("no_timeout", done, 1);
    check_val("latency", cyc, (n_eff == 0) ? 1 : n_eff + 4);
    check_val("reads", reads, n_eff);
    check_val("score", longint'($signed(out_score)), exp_score);
    check_val("bit", out_bit, (exp_score >= thr) ? 1 : 0);
    if (stall) begin
      held_score = out_score;
      for (int k = 0; k < 4; k++) begin
        start = 1'b1; num_words = 5'($urandom_range(1, 16));
        @(negedge clk);
        check_val("stall_valid", out_valid, 1);
        check_val("stall_score", out_score, held_score);
        check_val("stall_busy", busy, 1);
        check_val("stall_rd_en", rd_en, 0);
      end
      start = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    check_val("post_valid", out_valid, 0);
    check_val("post_busy", busy, 0);
  endtask

  initial begin
    int rd_cnt;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    num_words = '0; last_bits = '0; threshold = '0;
    rd_w = '0; rd_a = '0; core_pc = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; num_words = 5'd3;
    @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_rd_en", rd_en, 0);
    check_val("rst_rd_addr", rd_addr, 0);
    check_val("rst_valid", out_valid, 0);
    check_val("rst_score", out_score, 0);
    check_val("rst_bit", out_bit, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_val("start_in_rst_ignored", busy, 0);

    run_neuron(1, 0, 0, 0, 1, 0);
    run_neuron(3, 10, -138, 0, 2, 0);
    run_neuron(3, 10, -137, 0, 2, 0);
    run_neuron(2, 10, 0, 0, 3, 0);
    run_neuron(0, 5, 0, 0, 0, 0);
    run_neuron(20, 0, 0, 1, 0, 0);
    run_neuron(5, 33, 1, 1, 0, 1);

    // Reset in the 4th FETCH cycle discards the neuron.
    start = 1'b1; num_words = 5'd8; last_bits = 7'd0; out_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    rd_cnt = 0;
    for (int c = 0; c < 20 && rd_cnt < 4; c++) begin
      if (rd_en) rd_cnt++;
      if (rd_cnt < 4) @(negedge clk);
    end
    check_val("fetch_reached", rd_cnt, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_rd_en", rd_en, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_val("midrst_no_valid", out_valid, 0);
    end
    run_neuron(8, 0, 0, 1, 1, 0);

    for (int t = 0; t < 25; t++) begin
      run_neuron($urandom_range(0, 20), $urandom_range(0, 70),
                 int'($urandom_range(0, 2)) - 1, 1, 0, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
